bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 The block SHALL have no parameters; the input width is fixed at 8 bits and the output is fixed at 3 BCD digits.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge only.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to convert bin; sampled on the rising edge of clk.
REQ-005 bin  input  8  unsigned binary operand, range 0..255; sampled only when start is accepted.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  one-cycle pulse marking that the result outputs have just been updated.
REQ-008 bcd2  output  4  hundreds digit, range 0..2.
REQ-009 bcd1  output  4  tens digit, range 0..9.
REQ-010 bcd0  output  4  ones digit, range 0..9.
REQ-011 All outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.

Function
REQ-012 The algorithm SHALL be sequential shift-and-add-3 (double dabble), performing one bit per clock.
REQ-013 Internal datapath: 12-bit BCD accumulator {h,t,o}, 8-bit binary shift register, and 3-bit iteration counter.
REQ-014 The FSM SHALL have exactly two states: IDLE and CONV.
REQ-015 IDLE with start=1 at an edge SHALL load bin into the shift register, clear the accumulator and counter, and move to CONV.
REQ-016 IDLE with start=0 SHALL hold all state.
REQ-017 Each CONV edge SHALL apply add-3 correction to each of h, t and o independently.
REQ-018 Correction rule: a digit value 0..4 is unchanged; 5..9 becomes value+3 (5->8, 6->9, 7->10, 8->11, 9->12).
REQ-019 Digit values above 9 SHALL never occur before correction; no handling of them is required.
REQ-020 On the same CONV edge, the block SHALL shift {corrected h,t,o, shift reg} left by 1 as a 20-bit quantity, then increment the counter.
REQ-021 On the CONV edge where the counter equals 7 (the 8th shift), the block SHALL write the final digits to bcd2/bcd1/bcd0, assert done for the following cycle, and return to IDLE.
REQ-022 busy SHALL equal (state==CONV).
REQ-023 busy SHALL be high for exactly 8 cycles per conversion.
REQ-024 Latency: done SHALL be high in the 9th cycle after the edge that accepts start.
REQ-025 done SHALL be high for exactly 1 cycle per conversion.
REQ-026 bcd2/bcd1/bcd0 SHALL hold the previous result during a conversion, changing only on the edge that raises done.
REQ-027 start while busy=1 SHALL be ignored, with no queueing and no effect on the current conversion.
REQ-028 bin changing during CONV SHALL have no effect.
REQ-029 start=1 in the cycle where done=1 (state IDLE) SHALL be accepted, giving back-to-back conversions every 9 cycles.
REQ-030 start held high continuously SHALL cause a new conversion to be accepted on each return to IDLE.
REQ-031 Result correctness: for every bin in 0..255, 100*bcd2 + 10*bcd1 + bcd0 SHALL equal bin.

Reset
REQ-032 rst=1 at an edge SHALL force state to IDLE, busy=0, done=0, and bcd2=bcd1=bcd0=0.
REQ-033 rst=1 at an edge SHALL also clear the accumulator, shift register and counter.
REQ-034 rst SHALL take priority over start and over any in-progress conversion.
REQ-035 rst asserted mid-conversion SHALL abort that conversion with no done pulse and no partial result visible at the outputs.
REQ-036 In the first cycle after rst deasserts, the block SHALL accept start normally.

Verification
REQ-037 bin=0, start 1 cycle -> busy 8 cycles; done in cycle 9; bcd2/1/0=0/0/0.
REQ-038 bin=255 -> 2/5/5; bin=99 -> 0/9/9; bin=100 -> 1/0/0; bin=59 -> 0/5/9.
REQ-039 Exhaustive sweep of bin=0..255 with back-to-back starts -> every result matches the reference model, and done pulses occur exactly 9 cycles apart.
REQ-040 bin=128 accepted, then start with bin=7 pulsed at busy cycle 3 -> result 1/2/8; exactly one done pulse; no second conversion.
REQ-041 bin=200 accepted, then rst at busy cycle 5 -> no done pulse; outputs 0/0/0; busy=0 next cycle; a subsequent bin=42 conversion gives 0/4/2.
REQ-042 After a result of 2/5/5, start bin=13 -> outputs stay 2/5/5 for 8 cycles, then change to 0/1/3 together with done.

Source files
------------

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle for the sequential 8-bit binary to 3-digit BCD converter.
interface bin2bcd_seq_if;
  logic       start;
  logic [7:0] bin;
  logic       busy;
  logic       done;
  logic [3:0] bcd2;
  logic [3:0] bcd1;
  logic [3:0] bcd0;

  modport master (
    output start, bin,
    input  busy, done, bcd2, bcd1, bcd0
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd2, bcd1, bcd0
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 8-bit unsigned to hundreds/tens/ones BCD,
// one bit per clock, with the result register updated only when a conversion completes.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst,
  bin2bcd_seq_if.slave bus
);
  localparam int unsigned BIN_W = 8;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned ACC_W = 3 * DIG_W;
  localparam int unsigned SH_W  = ACC_W + BIN_W;
  localparam int unsigned CNT_W = 3;

  typedef enum logic {S_IDLE = 1'b0, S_CONV = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [BIN_W-1:0]   r_sr;
  logic [CNT_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_res;
  logic               r_done;
  logic               w_load;
  logic               w_step;
  logic               w_last;
  logic [SH_W-1:0]    w_shifted;

  // Add-3 correction applied to a BCD digit before it is doubled.
  function automatic logic [DIG_W-1:0] add3(input logic [DIG_W-1:0] d);
    return (d >= DIG_W'(5)) ? DIG_W'(d + DIG_W'(3)) : d;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_state_nxt = S_CONV;
      S_CONV: if (r_cnt == CNT_W'(BIN_W - 1)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    w_last = 1'b0;
    case (r_state)
      S_IDLE: w_load = bus.start;
      S_CONV: begin
        w_step = 1'b1;
        w_last = (r_cnt == CNT_W'(BIN_W - 1));
      end
      default: ;
    endcase
  end

  always_comb begin
    w_shifted = {add3(r_acc[ACC_W-1 -: DIG_W]),
                 add3(r_acc[2*DIG_W-1 -: DIG_W]),
                 add3(r_acc[DIG_W-1:0]),
                 r_sr} << 1;
  end

  // Datapath: accumulator and shift register march together; result only moves on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_sr   <= '0;
      r_cnt  <= '0;
      r_res  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_sr  <= bus.bin;
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_step) begin
        r_acc <= w_shifted[SH_W-1:BIN_W];
        r_sr  <= w_shifted[BIN_W-1:0];
        r_cnt <= CNT_W'(r_cnt + CNT_W'(1));
        if (w_last) begin
          r_res  <= w_shifted[SH_W-1:BIN_W];
          r_done <= 1'b1;
        end
      end
    end
  end

  assign bus.busy = (r_state == S_CONV);
  assign bus.done = r_done;
  assign bus.bcd2 = r_res[ACC_W-1 -: DIG_W];
  assign bus.bcd1 = r_res[2*DIG_W-1 -: DIG_W];
  assign bus.bcd0 = r_res[DIG_W-1:0];
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: directed conversions push expected digits,
// a negedge monitor pops and compares on every done pulse.
module tb_bin2bcd_seq;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  logic [11:0] sb[$];
  logic [11:0] exp_prev;
  logic        prev_done;

  bin2bcd_seq_if bus ();

  bin2bcd_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int b);
    return {4'(b / 100), 4'((b / 10) % 10), 4'(b % 10)};
  endfunction

  // Monitor: result check on done, done must be a single-cycle pulse.
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) check("done_width", int'(bus.done), 0);
      if (bus.done) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 required no pending result at %0t", $time);
        end else begin
          check("result", int'({bus.bcd2, bus.bcd1, bus.bcd0}), int'(sb.pop_front()));
        end
      end
      prev_done = bus.done;
    end
  end

  // Called with clk low; issues start, then follows the conversion until done.
  task automatic run_one(input logic [7:0] b, input logic [11:0] exp, input int glitch_at);
    int nbusy;
    int lat;
    nbusy = 0;
    lat   = 0;
    sb.push_back(exp);
    bus.start = 1'b1;
    bus.bin   = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == glitch_at) begin
        bus.start = 1'b1;
        bus.bin   = 8'd7;
      end else if (k == glitch_at + 1) begin
        bus.start = 1'b0;
      end
      if (bus.busy) nbusy++;
      if (bus.done) begin
        lat = k;
        break;
      end
      check("hold_prev", int'({bus.bcd2, bus.bcd1, bus.bcd0}), int'(exp_prev));
    end
    bus.start = 1'b0;
    check("latency", lat, 9);
    check("busy_cycles", nbusy, 8);
    exp_prev = exp;
  endtask

  initial begin
    int ndone;
    int t1;
    int t2;
    n_cmp     = 0;
    n_fail    = 0;
    exp_prev  = '0;
    prev_done = 1'b0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_bcd", int'({bus.bcd2, bus.bcd1, bus.bcd0}), 0);
    rst = 1'b0;
    @(negedge clk);

    run_one(8'd0,   12'h000, 0);
    run_one(8'd255, 12'h255, 0);
    run_one(8'd13,  12'h013, 0);
    run_one(8'd99,  12'h099, 0);
    run_one(8'd100, 12'h100, 0);
    run_one(8'd59,  12'h059, 0);

    // Start pulsed mid-conversion must be ignored.
    run_one(8'd128, 12'h128, 3);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("no_second_done", ndone, 0);
    check("idle_after_ignore", int'(bus.busy), 0);

    // Reset mid-conversion aborts with no done and cleared outputs.
    bus.start = 1'b1;
    bus.bin   = 8'd200;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 5) begin
        check("abort_busy_before", int'(bus.busy), 1);
        rst = 1'b1;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_bcd", int'({bus.bcd2, bus.bcd1, bus.bcd0}), 0);
    exp_prev = '0;
    run_one(8'd42, 12'h042, 0);

    // Exhaustive back-to-back sweep.
    for (int b = 0; b < 256; b++) run_one(8'(b), ref_bcd(b), 0);

    // Start held high: a new conversion on each return to idle.
    sb.push_back(12'h077);
    sb.push_back(12'h077);
    bus.start = 1'b1;
    bus.bin   = 8'd77;
    ndone = 0;
    t1 = 0;
    t2 = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        if (ndone == 1) t1 = k;
        else begin
          t2 = k;
          bus.start = 1'b0;
          break;
        end
      end
    end
    bus.start = 1'b0;
    check("held_first", t1, 9);
    check("held_gap", t2 - t1, 9);

    repeat (12) @(negedge clk);
    check("held_stopped", int'(bus.busy), 0);
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
